// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the single regfile write port.
// Three valid/ready requesters compete; the winner is registered into a
// one-stage write buffer that drives W_addr/W_data/wr_enable directly.
// Optional feature macro: REGFILE_ARB_FWD_EN adds combinational forwarding
// of the buffered write to the two regfile read ports.
module regfile_wb_arbiter #(
  parameter int unsigned width = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic [2:0]         req_valid,
  input  logic [14:0]        req_addr,
  input  logic [3*width-1:0] req_data,
  output logic [2:0]         req_ready,
  output logic [4:0]         W_addr,
  output logic [width-1:0]   W_data,
  output logic               wr_enable
`ifdef REGFILE_ARB_FWD_EN
  ,
  input  logic [4:0]         A_addr,
  input  logic [4:0]         B_addr,
  output logic               A_fwd_valid,
  output logic               B_fwd_valid,
  output logic [width-1:0]   A_fwd_data,
  output logic [width-1:0]   B_fwd_data
`endif
);

  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [4:0]       w_addr_q, w_addr_d;
  logic [width-1:0] w_data_q, w_data_d;
  logic             wr_en_q, wr_en_d;

  logic [1:0]       ptr_eff;
  logic [1:0]       cand0, cand1, cand2;
  logic [3:0]       valid_pad;
  logic             grant_valid;
  logic [1:0]       grant_idx;
  logic [4:0]       sel_addr;
  logic [width-1:0] sel_data;

  // Modulo-3 increment; never produces 3.
  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v >= 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Unreachable pointer value 3 behaves as 0.
  assign ptr_eff   = (rr_ptr_q == 2'd3) ? 2'd0 : rr_ptr_q;
  assign cand0     = ptr_eff;
  assign cand1     = inc3(cand0);
  assign cand2     = inc3(cand1);
  assign valid_pad = {1'b0, req_valid};

  // Priority search starting at the round-robin pointer; stall or reset blocks all grants.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    if (valid_pad[cand0]) begin
      grant_valid = 1'b1;
      grant_idx   = cand0;
    end else if (valid_pad[cand1]) begin
      grant_valid = 1'b1;
      grant_idx   = cand1;
    end else if (valid_pad[cand2]) begin
      grant_valid = 1'b1;
      grant_idx   = cand2;
    end
    if (stall || !reset) begin
      grant_valid = 1'b0;
    end
    req_ready = 3'b000;
    if (grant_valid) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Select the winning requester's address and data.
  always_comb begin
    sel_addr = req_addr[4:0];
    sel_data = req_data[width-1:0];
    unique case (grant_idx)
      2'd0: begin
        sel_addr = req_addr[4:0];
        sel_data = req_data[width-1:0];
      end
      2'd1: begin
        sel_addr = req_addr[9:5];
        sel_data = req_data[2*width-1:width];
      end
      default: begin
        sel_addr = req_addr[14:10];
        sel_data = req_data[3*width-1:2*width];
      end
    endcase
  end

  // Next state of the write buffer and pointer; R0 writes load but never enable.
  always_comb begin
    rr_ptr_d = ptr_eff;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    wr_en_d  = 1'b0;
    if (grant_valid) begin
      w_addr_d = sel_addr;
      w_data_d = sel_data;
      wr_en_d  = (sel_addr != 5'd0);
      rr_ptr_d = inc3(grant_idx);
    end
  end

  // Buffer and pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= 2'd0;
      w_addr_q <= 5'd0;
      w_data_q <= '0;
      wr_en_q  <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      wr_en_q  <= wr_en_d;
    end
  end

  assign W_addr    = w_addr_q;
  assign W_data    = w_data_q;
  assign wr_enable = wr_en_q;

`ifdef REGFILE_ARB_FWD_EN
  // Cover the cycle where the regfile still returns the pre-write value.
  always_comb begin
    A_fwd_valid = wr_en_q && (w_addr_q == A_addr) && (A_addr != 5'd0);
    B_fwd_valid = wr_en_q && (w_addr_q == B_addr) && (B_addr != 5'd0);
    A_fwd_data  = A_fwd_valid ? w_data_q : '0;
    B_fwd_data  = B_fwd_valid ? w_data_q : '0;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised scoreboard bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
  localparam int W = 64;

  logic           clk;
  logic           reset;
  logic           stall;
  logic [2:0]     req_valid;
  logic [14:0]    req_addr;
  logic [3*W-1:0] req_data;
  logic [2:0]     req_ready;
  logic [4:0]     W_addr;
  logic [W-1:0]   W_data;
  logic           wr_enable;
`ifdef REGFILE_ARB_FWD_EN
  logic [4:0]     A_addr, B_addr;
  logic           A_fwd_valid, B_fwd_valid;
  logic [W-1:0]   A_fwd_data, B_fwd_data;
`endif

  regfile_wb_arbiter #(.width(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .W_addr    (W_addr),
    .W_data    (W_data),
    .wr_enable (wr_enable)
`ifdef REGFILE_ARB_FWD_EN
    ,
    .A_addr      (A_addr),
    .B_addr      (B_addr),
    .A_fwd_valid (A_fwd_valid),
    .B_fwd_valid (B_fwd_valid),
    .A_fwd_data  (A_fwd_data),
    .B_fwd_data  (B_fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]   addr;
    logic [W-1:0] data;
    logic         we;
  } wb_t;

  int total = 0;
  int bad   = 0;

  logic [2:0] ready_q[$];
  wb_t        wb_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference state: requests pending per requester and the abstract pointer.
  bit           pend[3];
  logic [4:0]   p_addr[3];
  logic [W-1:0] p_data[3];
  int           ptr;
  wb_t          m;

  // Monitor: ready checked mid-low-phase, buffer checked just after the edge.
  initial begin
    ready_q.delete();
    wb_q.delete();
    forever begin
      @(negedge clk);
      #2;
      if (ready_q.size() > 0) begin
        logic [2:0] er;
        er = ready_q.pop_front();
        check("req_ready", W'(req_ready), W'(er));
      end
      @(posedge clk);
      #1;
      if (wb_q.size() > 0) begin
        wb_t e;
        e = wb_q.pop_front();
        check("wr_enable", W'(wr_enable), W'(e.we));
        check("W_addr", W'(W_addr), W'(e.addr));
        check("W_data", W_data, e.data);
`ifdef REGFILE_ARB_FWD_EN
        check("A_fwd_valid", W'(A_fwd_valid),
              W'(e.we && e.addr == A_addr && A_addr != 0));
        check("A_fwd_data", A_fwd_data,
              (e.we && e.addr == A_addr && A_addr != 0) ? e.data : '0);
        check("B_fwd_valid", W'(B_fwd_valid),
              W'(e.we && e.addr == B_addr && B_addr != 0));
`endif
      end
    end
  end

  initial begin
    int win;
    reset     = 1'b0;
    stall     = 1'b0;
    req_valid = 3'b111;
    req_addr  = {5'd3, 5'd2, 5'd1};
    req_data  = '1;
`ifdef REGFILE_ARB_FWD_EN
    A_addr = 5'd0;
    B_addr = 5'd0;
`endif
    repeat (3) @(negedge clk);
    check("rst_ready", W'(req_ready), '0);
    check("rst_wr_enable", W'(wr_enable), '0);
    check("rst_W_addr", W'(W_addr), '0);
    check("rst_W_data", W_data, '0);
    req_valid = 3'b000;
    reset     = 1'b1;
    ptr    = 0;
    m.addr = '0;
    m.data = '0;
    m.we   = 1'b0;
    for (int i = 0; i < 3; i++) pend[i] = 1'b0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      // Arm new requests; early cycles run the all-valid round-robin pattern.
      for (int i = 0; i < 3; i++) begin
        if (!pend[i]) begin
          if (cyc < 14) begin
            pend[i]   = 1'b1;
            p_addr[i] = 5'(i + 1);
            p_data[i] = {$urandom, $urandom};
          end else if ($urandom_range(0, 99) < 55) begin
            pend[i]   = 1'b1;
            p_addr[i] = 5'($urandom_range(0, 7));
            p_data[i] = {$urandom, $urandom};
          end
        end
      end
      if (cyc < 8) stall = 1'b0;
      else if (cyc < 11) stall = 1'b1;
      else if (cyc < 14) stall = 1'b0;
      else stall = ($urandom_range(0, 9) < 2);
      for (int i = 0; i < 3; i++) begin
        req_valid[i]           = pend[i];
        req_addr[5*i +: 5]     = p_addr[i];
        req_data[W*i +: W]     = p_data[i];
      end
`ifdef REGFILE_ARB_FWD_EN
      A_addr = ($urandom_range(0, 1) == 0) ? m.addr : 5'($urandom_range(0, 7));
      B_addr = 5'($urandom_range(0, 7));
`endif
      // Winner: first pending requester scanning from the pointer, mod 3.
      win = -1;
      if (!stall) begin
        for (int k = 0; k < 3; k++) begin
          if (win < 0 && pend[(ptr + k) % 3]) win = (ptr + k) % 3;
        end
      end
      if (win >= 0) begin
        ready_q.push_back(3'(1 << win));
        m.addr = p_addr[win];
        m.data = p_data[win];
        m.we   = (p_addr[win] != 0);
        ptr    = (win + 1) % 3;
        pend[win] = 1'b0;
      end else begin
        ready_q.push_back(3'b000);
        m.we = 1'b0;
      end
      wb_q.push_back(m);
    end

    // Drain the scoreboard within a bounded number of cycles.
    begin
      int waited = 0;
      while ((ready_q.size() > 0 || wb_q.size() > 0) && waited < 20) begin
        @(posedge clk);
        waited++;
      end
      total++;
      if (ready_q.size() > 0 || wb_q.size() > 0) begin
        bad++;
        $display("FAIL drain got=%0d want=0", ready_q.size() + wb_q.size());
      end
    end

    // Reset mid-operation kills the buffered write at once.
    @(negedge clk);
    stall     = 1'b0;
    req_valid = 3'b111;
    req_addr  = {5'd5, 5'd5, 5'd5};
    @(posedge clk);
    #1;
    check("pre_rst_wr_enable", W'(wr_enable), W'(1));
    check("pre_rst_W_addr", W'(W_addr), W'(5));
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_wr_enable", W'(wr_enable), '0);
    check("mid_rst_ready", W'(req_ready), '0);
    check("mid_rst_W_addr", W'(W_addr), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
